// File: rtl/igpu_top.sv
// Two-stage min-base residual compressor for one 32-pixel RGBA block (1024 bits -> 1 or 2 cache lines).
// Define IGPU_STATS_EN to add the saturating compressed_count output.

package types;
  localparam int NPIX = 32;

  typedef struct packed {
    logic [NPIX-1:0][3:0][7:0] pixels;
  } pixels_t;
endpackage

module igpu_residual
  import types::*;
#(
  parameter int LINE_W = 512,
  parameter int KMAX_C = 3
) (
  input  pixels_t                i_px,
  input  logic [3:0][7:0]        i_min,
  input  logic [3:0][7:0]        i_max,
  output logic                   o_compressable,
  output logic [1:0][LINE_W-1:0] o_lines
);
  logic [NPIX*4-1:0][7:0]        w_bytes;
  logic [NPIX*4-1:0][KMAX_C-1:0] w_res;
  logic [7:0]                    w_max_range;
  logic [3:0]                    w_k;
  logic [LINE_W-1:0]             w_cline;
  logic [2*LINE_W-1:0]           w_raw;

  assign w_bytes = i_px;
  assign w_raw   = i_px;

  // NOTE: every always_comb variable gets a default first so no path can infer a latch.
  always_comb begin
    w_max_range = '0;
    for (int c = 0; c < 4; c++) begin
      if ((i_max[c] - i_min[c]) > w_max_range) w_max_range = i_max[c] - i_min[c];
    end
    w_k = '0;
    for (int b = 0; b < 8; b++) begin
      if (w_max_range[b]) w_k = 4'(b + 1);
    end
  end

  assign o_compressable = (w_k <= 4'(KMAX_C));

  // Residuals only ever need KMAX_C bits when the block is compressible.
  always_comb begin
    w_res = '0;
    for (int j = 0; j < NPIX * 4; j++) begin
      w_res[j] = KMAX_C'(w_bytes[j] - i_min[j[1:0]]);
    end
  end

  always_comb begin
    w_cline        = '0;
    w_cline[31:0]  = i_min;
    w_cline[35:32] = w_k;
    for (int kk = 1; kk <= KMAX_C; kk++) begin
      if (w_k == 4'(kk)) begin
        for (int j = 0; j < NPIX * 4; j++) begin
          for (int b = 0; b < kk; b++) begin
            w_cline[36 + j*kk + b] = w_res[j][b];
          end
        end
      end
    end
  end

  always_comb begin
    o_lines = w_raw;
    if (o_compressable) begin
      o_lines[0] = w_cline;
      o_lines[1] = '0;
    end
  end
endmodule

module igpu_top
  import types::*;
#(
  parameter int LINE_W = 512,
  parameter int KMAX_C = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  pixels_t                pixels,
  output logic [1:0][LINE_W-1:0] lines,
  output logic [1:0]             flag
`ifdef IGPU_STATS_EN
  ,
  output logic [31:0]            compressed_count
`endif
);
  typedef struct packed {
    logic            valid;
    logic [3:0][7:0] mn;
    logic [3:0][7:0] mx;
    pixels_t         px;
  } hr_t;

  typedef struct packed {
    logic                   valid;
    logic                   compressable;
    logic [1:0][LINE_W-1:0] lines;
  } cr_t;

  hr_t                    hr_reg;
  cr_t                    cr_reg;
  logic [3:0][7:0]        w_min;
  logic [3:0][7:0]        w_max;
  logic                   w_compressable;
  logic [1:0][LINE_W-1:0] w_lines;

  always_comb begin
    w_min = '1;
    w_max = '0;
    for (int i = 0; i < NPIX; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (pixels.pixels[i][c] < w_min[c]) w_min[c] = pixels.pixels[i][c];
        if (pixels.pixels[i][c] > w_max[c]) w_max[c] = pixels.pixels[i][c];
      end
    end
  end

  igpu_residual #(
    .LINE_W (LINE_W),
    .KMAX_C (KMAX_C)
  ) residual_inst (
    .i_px           (hr_reg.px),
    .i_min          (hr_reg.mn),
    .i_max          (hr_reg.mx),
    .o_compressable (w_compressable),
    .o_lines        (w_lines)
  );

  // NOTE: the wide pixel copy is reset too, so lines read 0 while reset holds, not stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr_reg <= '0;
      cr_reg <= '0;
    end else begin
      // NOTE: non-blocking updates let stage 2 see the previous stage-1 value on the same edge.
      hr_reg <= '{valid: 1'b1, mn: w_min, mx: w_max, px: pixels};
      cr_reg <= '{valid:        hr_reg.valid,
                  compressable: w_compressable,
                  lines:        hr_reg.valid ? w_lines : '0};
    end
  end

  assign lines = cr_reg.lines;
  assign flag  = !cr_reg.valid       ? 2'b00 :
                 cr_reg.compressable ? 2'b01 : 2'b11;

`ifdef IGPU_STATS_EN
  logic [31:0] r_compressed_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_compressed_count <= '0;
    end else if (hr_reg.valid && w_compressable && (r_compressed_count != '1)) begin
      r_compressed_count <= r_compressed_count + 32'd1;
    end
  end

  assign compressed_count = r_compressed_count;
`endif
endmodule

// File: tb/tb_igpu_top.sv
// Directed/table-driven bench for igpu_top: a bit-serial reference packer supplies expected lines.
// Checks compressed_count as well when built with IGPU_STATS_EN.
module tb_igpu_top;
  import types::*;

  logic               clk = 1'b0;
  logic               rst;
  pixels_t            pixels;
  logic [1:0][511:0]  lines;
  logic [1:0]         flag;
`ifdef IGPU_STATS_EN
  logic [31:0]        compressed_count;
`endif

  igpu_top dut (
    .clk              (clk),
    .rst              (rst),
    .pixels           (pixels),
    .lines            (lines),
    .flag             (flag)
`ifdef IGPU_STATS_EN
    ,
    .compressed_count (compressed_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]    flag;
    logic [1023:0] bits;
    int            k;
  } res_t;

  typedef struct {
    string      name;
    pixels_t    px;
    logic [1:0] exp_flag;
    int         exp_k;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lines(input string name, input logic [1023:0] exp);
    logic [1023:0] act;
    int            w;
    act = lines;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      w = 0;
      for (int i = 31; i >= 0; i--) if (act[32*i +: 32] !== exp[32*i +: 32]) w = i;
      $display("FAIL %s: lines word %0d got %08h, expected %08h", name, w, act[32*w +: 32], exp[32*w +: 32]);
    end
  endtask

  // Reference: appends residual bits one at a time from bit 36 upward.
  function automatic res_t model(input pixels_t p);
    res_t       m;
    logic [7:0] mn [4];
    logic [7:0] mx [4];
    int         r, pos;
    for (int c = 0; c < 4; c++) begin
      mn[c] = 8'hFF;
      mx[c] = 8'h00;
    end
    for (int i = 0; i < 32; i++)
      for (int c = 0; c < 4; c++) begin
        if (p.pixels[i][c] < mn[c]) mn[c] = p.pixels[i][c];
        if (p.pixels[i][c] > mx[c]) mx[c] = p.pixels[i][c];
      end
    r = 0;
    for (int c = 0; c < 4; c++) if (int'(mx[c]) - int'(mn[c]) > r) r = int'(mx[c]) - int'(mn[c]);
    m.k = 0;
    while ((1 << m.k) <= r) m.k++;
    m.bits = '0;
    if (m.k <= 3) begin
      m.flag = 2'b01;
      for (int c = 0; c < 4; c++) m.bits[8*c +: 8] = mn[c];
      m.bits[35:32] = 4'(m.k);
      pos = 36;
      for (int i = 0; i < 32; i++)
        for (int c = 0; c < 4; c++) begin
          logic [7:0] d;
          d = p.pixels[i][c] - mn[c];
          for (int b = 0; b < m.k; b++) begin
            m.bits[pos] = d[b];
            pos++;
          end
        end
    end else begin
      m.flag = 2'b11;
      for (int i = 0; i < 32; i++)
        for (int c = 0; c < 4; c++) m.bits[8*(4*i + c) +: 8] = p.pixels[i][c];
    end
    return m;
  endfunction

  function automatic pixels_t fill(input logic [7:0] v);
    pixels_t p;
    for (int i = 0; i < 32; i++)
      for (int c = 0; c < 4; c++) p.pixels[i][c] = v;
    return p;
  endfunction

  function automatic pixels_t rand_px(input int lo, input int hi);
    pixels_t p;
    for (int i = 0; i < 32; i++)
      for (int c = 0; c < 4; c++) p.pixels[i][c] = 8'($urandom_range(hi, lo));
    return p;
  endfunction

  // Decodes the DUT's compressed line independently and compares against the source block.
  task automatic decode_check(input string name, input pixels_t p);
    logic       ok;
    int         k;
    logic [7:0] mn, res;
    ok = (flag == 2'b01) && (lines[1] == '0);
    k  = int'(lines[0][35:32]);
    for (int i = 0; i < 32; i++)
      for (int c = 0; c < 4; c++) begin
        mn  = lines[0][8*c +: 8];
        res = '0;
        for (int b = 0; b < k; b++) res[b] = lines[0][36 + (4*i + c)*k + b];
        if (8'(mn + res) !== p.pixels[i][c]) ok = 1'b0;
      end
    check(name, 64'(ok), 64'd1);
  endtask

  vec_t    vecs [10];
  pixels_t blk  [100];
  pixels_t p;
  res_t    m;
  int      model_cmp;

  initial begin
    vecs[0] = '{"all05", fill(8'h05), 2'b01, 0};
    vecs[1] = '{"all00", fill(8'h00), 2'b01, 0};
    vecs[2] = '{"allFF", fill(8'hFF), 2'b01, 0};
    p = fill(8'h0A);
    for (int i = 0; i < 32; i++) p.pixels[i][1] = 8'h03;
    p.pixels[0][1] = 8'h00;
    p.pixels[1][1] = 8'h07;
    vecs[3] = '{"g_range7", p, 2'b01, 3};
    p.pixels[1][1] = 8'h08;
    vecs[4] = '{"g_range8", p, 2'b11, 4};
    p = fill(8'h00);
    for (int i = 0; i < 32; i++) p.pixels[i][0] = 8'(i);
    vecs[5] = '{"r_ramp", p, 2'b11, 5};
    p = fill(8'h80);
    for (int i = 1; i < 32; i += 2) p.pixels[i][3] = 8'h81;
    vecs[6] = '{"a_range1", p, 2'b01, 1};
    p = fill(8'h40);
    p.pixels[5][2] = 8'h43;
    vecs[7] = '{"b_range3", p, 2'b01, 2};
    p = fill(8'hF8);
    p.pixels[31][0] = 8'hFF;
    p.pixels[0][3]  = 8'hFF;
    vecs[8] = '{"high_range7", p, 2'b01, 3};
    p = fill(8'h00);
    p.pixels[3][2] = 8'hFF;
    vecs[9] = '{"full_range", p, 2'b11, 8};

    // Reset held with changing input: outputs stay cleared.
    rst    = 1'b0;
    pixels = rand_px(0, 255);
    #1;
    check("reset_flag_t0", 64'(flag), 64'd0);
    check_lines("reset_lines_t0", '0);
    for (int n = 0; n < 3; n++) begin
      pixels = rand_px(0, 255);
      step();
      check($sformatf("reset_flag_%0d", n), 64'(flag), 64'd0);
      check_lines($sformatf("reset_lines_%0d", n), '0);
    end

    // First result lands exactly on the second edge after release.
    pixels = fill(8'h05);
    rst    = 1'b1;
    step();
    check("release_edge1_flag", 64'(flag), 64'd0);
    step();
    check("release_edge2_flag", 64'(flag), 64'd1);
    check_lines("release_edge2_all05", {988'd0, 36'h0_0505_0505});

    foreach (vecs[v]) begin
      pixels = vecs[v].px;
      step();
      step();
      check({vecs[v].name, "_flag"}, 64'(flag), 64'(vecs[v].exp_flag));
      if (vecs[v].exp_flag == 2'b01) check({vecs[v].name, "_k"}, 64'(lines[0][35:32]), 64'(vecs[v].exp_k));
      m = model(vecs[v].px);
      check_lines({vecs[v].name, "_lines"}, m.bits);
    end

    for (int n = 0; n < 3; n++) begin
      p      = rand_px(0, 6);
      pixels = p;
      step();
      step();
      m = model(p);
      check($sformatf("small_flag_%0d", n), 64'(flag), 64'd1);
      check($sformatf("small_k_%0d", n), 64'(lines[0][35:32]), 64'(m.k));
      check_lines($sformatf("small_lines_%0d", n), m.bits);
      decode_check($sformatf("small_decode_%0d", n), p);
    end

    // Back-to-back stream after a fresh reset.
    for (int n = 0; n < 100; n++) begin
      case (n % 3)
        0:       begin
                   int base;
                   base = int'($urandom_range(248, 0));
                   blk[n] = rand_px(base, base + 7);
                 end
        1:       blk[n] = rand_px(0, 255);
        default: blk[n] = fill(8'($urandom_range(255, 0)));
      endcase
    end
    rst = 1'b0;
    step();
    rst       = 1'b1;
    model_cmp = 0;
    for (int n = 0; n <= 100; n++) begin
      if (n < 100) pixels = blk[n];
      step();
      if (n >= 1) begin
        m = model(blk[n-1]);
        if (m.flag == 2'b01) model_cmp++;
        check($sformatf("stream_flag_%0d", n - 1), 64'(flag), 64'(m.flag));
        check_lines($sformatf("stream_lines_%0d", n - 1), m.bits);
      end
    end
`ifdef IGPU_STATS_EN
    check("compressed_count", 64'(compressed_count), 64'(model_cmp));
`endif

    // Asynchronous reset mid-operation clears both stages at once.
    pixels = fill(8'h33);
    step();
    step();
    check("midrst_before_flag", 64'(flag), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_async_flag", 64'(flag), 64'd0);
    check_lines("midrst_async_lines", '0);
    step();
    check("midrst_held_flag", 64'(flag), 64'd0);
    p      = vecs[4].px;
    pixels = p;
    rst    = 1'b1;
    step();
    check("midrst_edge1_flag", 64'(flag), 64'd0);
    step();
    m = model(p);
    check("midrst_edge2_flag", 64'(flag), 64'd3);
    check_lines("midrst_edge2_lines", m.bits);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
